// File: rtl/mem_stage_lsu_pkg.sv
// Shared RV32I memory-stage types and helpers.
// Decode (RVFI rmask/wmask) and the LSU both use these helpers, so their
// view of lane masks and alignment cannot drift apart.
package mem_stage_lsu_pkg;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_BUSY = 1'b1
    } lsu_state_t;

    // Only the fields the memory stage consumes.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [4:0] dest;
    } rv32i_control_word;

    // funct3 encodings used by the load aligner (loads: bit 2 = unsigned).
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Access size lives in funct3[1:0]; 2'b10 and the unused 2'b11 are words.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    function automatic logic [3:0] mem_byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: mem_byte_en = 4'b0001 << off;
            SZ_HALF: mem_byte_en = 4'b0011 << off;
            default: mem_byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = off[0];
            default: misaligned = |off;
        endcase
    endfunction

    // Replicate store data so the cache can take any lane without a shifter.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: store_data = {4{wdata[7:0]}};
            SZ_HALF: store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load aligner: shifts the addressed lanes down and sign/zero-extends.
module lsu_load_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    // Pick the addressed byte/half and extend it according to funct3.
    always_comb begin
        w_shifted = i_rdata >> {i_offset, 3'b000};
        o_data    = w_shifted;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LBU:  o_data = {24'd0, w_shifted[7:0]};
            F3_LHU:  o_data = {16'd0, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one data-memory request per memory
// instruction, stalls the pipeline until the cache answers, and hands the
// aligned load result to writeback.
//
// Data-memory handshake: dmem_read/dmem_write act as "valid" and stay high,
// with address/byte_en/wdata held constant, until the cache returns a
// single-cycle dmem_resp (the "ready"); the request drops on the following
// cycle. A dmem_resp while no request is outstanding is ignored.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  rv32i_control_word in_ctrl,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_wdata,
    output logic              stall,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [31:0]       dmem_address,
    output logic [3:0]        dmem_byte_en,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_resp,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_dest,
    output logic              trap,
    output lsu_state_t        dbg_state
);

    // Last counter value before abort; unused when the timeout is disabled.
    localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic [2:0]  r_funct3;
    logic [1:0]  r_offset;
    logic [4:0]  r_dest;
    logic [31:0] r_tcnt;

    logic        w_mem_op;
    logic        w_misal;
    logic        w_idle;
    logic        w_busy;
    logic        w_accept;
    logic        w_mis_trap;
    logic        w_timeout;
    logic [31:0] w_load_val;

    assign w_mem_op   = in_ctrl.mem_read | in_ctrl.mem_write;
    assign w_misal    = misaligned(in_funct3[1:0], in_addr[1:0]);
    assign w_idle     = (r_state == LSU_IDLE);
    assign w_busy     = (r_state == LSU_BUSY);
    assign w_accept   = w_idle & in_valid & w_mem_op & ~w_misal;
    assign w_mis_trap = w_idle & in_valid & w_mem_op & w_misal;
    // A response in the same cycle as the last allowed one wins over abort.
    assign w_timeout  = (TIMEOUT_CYCLES != 0) & w_busy & ~dmem_resp & (r_tcnt == TO_LAST);

    // Released on the response cycle so the pipeline advances on that edge.
    assign stall      = w_accept | (w_busy & ~dmem_resp & ~w_timeout);
    assign dbg_state  = r_state;

    lsu_load_align u_align (
        .i_rdata  (dmem_rdata),
        .i_offset (r_offset),
        .i_funct3 (r_funct3),
        .o_data   (w_load_val)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= LSU_IDLE;
        else      r_state <= w_next;
    end

    // Next-state: one outstanding request, closed by response or timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            LSU_IDLE: if (w_accept) w_next = LSU_BUSY;
            LSU_BUSY: if (dmem_resp || w_timeout) w_next = LSU_IDLE;
            default:  w_next = LSU_IDLE;
        endcase
    end

    // Request, writeback, trap and timeout registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            dmem_address <= 32'd0;
            dmem_byte_en <= 4'd0;
            dmem_wdata   <= 32'd0;
            wb_valid     <= 1'b0;
            wb_data      <= 32'd0;
            wb_dest      <= 5'd0;
            trap         <= 1'b0;
            r_funct3     <= 3'd0;
            r_offset     <= 2'd0;
            r_dest       <= 5'd0;
            r_tcnt       <= 32'd0;
        end else begin
            wb_valid <= 1'b0;
            trap     <= w_mis_trap | w_timeout;
            if (w_accept) begin
                dmem_read    <= in_ctrl.mem_read;
                dmem_write   <= in_ctrl.mem_write;
                dmem_address <= {in_addr[31:2], 2'b00};
                dmem_byte_en <= mem_byte_en(in_funct3[1:0], in_addr[1:0]);
                dmem_wdata   <= store_data(in_funct3[1:0], in_wdata);
                r_funct3     <= in_funct3;
                r_offset     <= in_addr[1:0];
                r_dest       <= in_ctrl.dest;
                r_tcnt       <= 32'd0;
            end else if (w_busy) begin
                if (dmem_resp) begin
                    dmem_read  <= 1'b0;
                    dmem_write <= 1'b0;
                    if (dmem_read) begin
                        wb_valid <= 1'b1;
                        wb_data  <= w_load_val;
                        wb_dest  <= r_dest;
                    end
                end else if (w_timeout) begin
                    dmem_read  <= 1'b0;
                    dmem_write <= 1'b0;
                end else begin
                    r_tcnt <= r_tcnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu. Instance A never times out and carries
// the functional checks; instance B (4-cycle timeout) shares the stimulus
// and is examined for the abort path.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b0;

    // ---------------- stimulus signals ----------------
    logic              in_valid = 1'b0;
    rv32i_control_word in_ctrl = '0;
    logic [2:0]        in_funct3 = 3'd0;
    logic [31:0]       in_addr = 32'd0;
    logic [31:0]       in_wdata = 32'd0;
    logic              resp_a = 1'b0;
    logic              resp_b = 1'b0;
    logic [31:0]       rdata = 32'd0;

    logic stall_a, rd_a, wr_a, wb_valid_a, trap_a;
    logic [31:0] addr_a, wdata_a, wb_data_a;
    logic [3:0] be_a;
    logic [4:0] wb_dest_a;
    lsu_state_t st_a;

    logic stall_b, rd_b, wr_b, wb_valid_b, trap_b;
    logic [31:0] addr_b, wdata_b, wb_data_b;
    logic [3:0] be_b;
    logic [4:0] wb_dest_b;
    lsu_state_t st_b;

    mem_stage_lsu #(.TIMEOUT_CYCLES(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .stall(stall_a), .dmem_read(rd_a), .dmem_write(wr_a),
        .dmem_address(addr_a), .dmem_byte_en(be_a), .dmem_wdata(wdata_a),
        .dmem_resp(resp_a), .dmem_rdata(rdata), .wb_valid(wb_valid_a),
        .wb_data(wb_data_a), .wb_dest(wb_dest_a), .trap(trap_a), .dbg_state(st_a)
    );

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .stall(stall_b), .dmem_read(rd_b), .dmem_write(wr_b),
        .dmem_address(addr_b), .dmem_byte_en(be_b), .dmem_wdata(wdata_b),
        .dmem_resp(resp_b), .dmem_rdata(rdata), .wb_valid(wb_valid_b),
        .wb_data(wb_data_b), .wb_dest(wb_dest_b), .trap(trap_b), .dbg_state(st_b)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [69:0] exp_req_q[$];   // {read, write, address, byte_en, wdata}
    logic [36:0] exp_wb_q[$];    // {dest, data}
    int exp_trap_cnt = 0;

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [95:0] got);
        checks++;
        errors++;
        $display("FAIL %s: got %h expected none", name, got);
    endtask

    // Monitor for instance A: every request cycle, every wb pulse, every trap.
    logic        prev_req = 1'b0;
    logic [69:0] cur_req = '0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_req = 1'b0;
        end else begin
            if (rd_a | wr_a) begin
                if (!prev_req) begin
                    if (exp_req_q.size() == 0) fail_now("unexpected_req", {rd_a, wr_a, addr_a});
                    else cur_req = exp_req_q.pop_front();
                end
                chk("req_fields", {rd_a, wr_a, addr_a, be_a, wdata_a}, cur_req);
            end
            prev_req = rd_a | wr_a;
            if (wb_valid_a) begin
                if (exp_wb_q.size() == 0) fail_now("unexpected_wb", {wb_dest_a, wb_data_a});
                else chk("wb_result", {wb_dest_a, wb_data_a}, exp_wb_q.pop_front());
            end
            if (trap_a) begin
                if (exp_trap_cnt == 0) fail_now("unexpected_trap", trap_a);
                else exp_trap_cnt--;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] dest);
        in_valid          = v;
        in_ctrl.mem_read  = rd;
        in_ctrl.mem_write = wr;
        in_ctrl.dest      = dest;
        in_funct3         = f3;
        in_addr           = addr;
        in_wdata          = wd;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    endtask

    // Issue one aligned memory op; cache answers after 'delay' request cycles.
    task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] dest,
                          input int delay, input logic [31:0] rdat, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_wb, input int exp_stall);
        int sc;
        sc = 0;
        exp_req_q.push_back({rd, wr, addr & 32'hFFFF_FFFC, exp_be, exp_wd});
        if (rd) exp_wb_q.push_back({dest, exp_wb});
        drive(1'b1, rd, wr, f3, addr, wd, dest);
        @(negedge clk); if (stall_a) sc++;
        @(posedge clk); #1; idle_inputs();
        for (int c = 0; c < delay; c++) begin
            @(negedge clk); if (stall_a) sc++;
            @(posedge clk); #1;
        end
        resp_a = 1'b1; resp_b = 1'b1; rdata = rdat;
        @(negedge clk); if (stall_a) sc++;
        @(posedge clk); #1;
        resp_a = 1'b0; resp_b = 1'b0; rdata = 32'd0;
        @(negedge clk);
        chk({tag, "_stall_cycles"}, sc, exp_stall);
        chk({tag, "_wb_pulse"}, wb_valid_a, rd);
        chk({tag, "_req_drop"}, {rd_a, wr_a}, 2'b00);
        @(posedge clk); #1;
        @(negedge clk); chk({tag, "_wb_one_cycle"}, wb_valid_a, 1'b0);
        @(posedge clk); #1;
    endtask

    // Issue a misaligned op: expect no stall, no request, a one-cycle trap.
    task automatic run_mis(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] addr);
        exp_trap_cnt++;
        drive(1'b1, rd, wr, f3, addr, 32'h1111_2222, 5'd3);
        @(negedge clk); chk({tag, "_stall"}, stall_a, 1'b0);
        @(posedge clk); #1; idle_inputs();
        @(negedge clk);
        chk({tag, "_trap"}, trap_a, 1'b1);
        chk({tag, "_no_req"}, {rd_a, wr_a}, 2'b00);
        @(posedge clk); #1;
        @(negedge clk); chk({tag, "_trap_one_cycle"}, trap_a, 1'b0);
        @(posedge clk); #1;
    endtask

    // Non-memory or invalid slot: nothing must happen.
    task automatic run_nop(input string tag, input logic v, input logic rd, input logic wr);
        drive(v, rd, wr, 3'b010, 32'h0000_5000, 32'd0, 5'd4);
        @(negedge clk); chk({tag, "_stall"}, stall_a, 1'b0);
        @(posedge clk); #1; idle_inputs();
        @(negedge clk);
        chk({tag, "_no_req"}, {rd_a, wr_a}, 2'b00);
        chk({tag, "_no_trap"}, trap_a, 1'b0);
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int sc;
        int bc;
        logic seen;

        // Reset values
        @(posedge clk); #1;
        chk("rst_stall", stall_a, 1'b0);
        chk("rst_req", {rd_a, wr_a}, 2'b00);
        chk("rst_addr_be_wd", {addr_a, be_a, wdata_a}, 68'd0);
        chk("rst_wb", {wb_valid_a, wb_dest_a, wb_data_a}, 38'd0);
        chk("rst_trap", trap_a, 1'b0);
        chk("rst_state", st_a, LSU_IDLE);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        //     tag    rd wr f3      addr          wdata         dest delay rdata         be       exp_wd        exp_wb        stall
        run_op("lb",  1, 0, 3'b000, 32'h0000_1003, 32'd0,        5'd5,  0, 32'h80FF_FF00, 4'b1000, 32'd0,        32'hFFFF_FF80, 1);
        run_op("sh",  0, 1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 5'd6,  0, 32'd0,        4'b1100, 32'hBEEF_BEEF, 32'd0,        1);
        run_mis("mis_lw", 1, 0, 3'b010, 32'h0000_3001);
        run_op("lw",  1, 0, 3'b010, 32'h0000_3000, 32'd0,        5'd7,  0, 32'h1234_5678, 4'b1111, 32'd0,        32'h1234_5678, 1);
        run_op("lhu", 1, 0, 3'b101, 32'h0000_4002, 32'd0,        5'd9,  5, 32'hABCD_0000, 4'b1100, 32'd0,        32'h0000_ABCD, 6);
        run_op("lbu", 1, 0, 3'b100, 32'h0000_5001, 32'd0,        5'd10, 1, 32'h0000_A500, 4'b0010, 32'd0,        32'h0000_00A5, 2);
        run_op("lh",  1, 0, 3'b001, 32'h0000_6002, 32'd0,        5'd11, 0, 32'h8001_1234, 4'b1100, 32'd0,        32'hFFFF_8001, 1);
        run_op("sb",  0, 1, 3'b000, 32'h0000_7001, 32'h1234_56C3, 5'd12, 2, 32'd0,        4'b0010, 32'hC3C3_C3C3, 32'd0,        3);
        run_op("sw",  0, 1, 3'b010, 32'h0000_7004, 32'hDEAD_BEEF, 5'd13, 0, 32'd0,        4'b1111, 32'hDEAD_BEEF, 32'd0,        1);
        run_op("f011",1, 0, 3'b011, 32'h0000_8000, 32'd0,        5'd31, 0, 32'hCAFE_F00D, 4'b1111, 32'd0,        32'hCAFE_F00D, 1);
        run_op("lbp", 1, 0, 3'b000, 32'h0000_8002, 32'd0,        5'd1,  0, 32'h007F_0000, 4'b0100, 32'd0,        32'h0000_007F, 1);
        run_mis("mis_sh",   0, 1, 3'b001, 32'h0000_9001);
        run_mis("mis_f011", 1, 0, 3'b011, 32'h0000_9002);
        run_mis("mis_lhu",  1, 0, 3'b101, 32'h0000_9003);
        run_nop("nonmem",  1'b1, 1'b0, 1'b0);
        run_nop("invalid", 1'b0, 1'b1, 1'b0);

        // Timeout on instance B; instance A stays busy on the same lw.
        exp_req_q.push_back({1'b1, 1'b0, 32'h0000_3000, 4'b1111, 32'd0});
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'd0, 5'd8);
        sc = 0; bc = 0; seen = 1'b0;
        @(negedge clk); if (stall_b) sc++;
        @(posedge clk); #1; idle_inputs();
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (trap_b) seen = 1'b1;
            else begin
                if (rd_b) bc++;
                if (stall_b) sc++;
            end
            @(posedge clk); #1;
        end
        chk("to_trap_seen", seen, 1'b1);
        chk("to_busy_cycles", bc, 4);
        chk("to_stall_cycles", sc, 4);
        @(negedge clk);
        chk("to_trap_one_cycle", trap_b, 1'b0);
        chk("to_req_dropped", rd_b, 1'b0);
        @(posedge clk); #1;
        resp_b = 1'b1; rdata = 32'h5555_AAAA;
        @(negedge clk); chk("to_stray_stall", stall_b, 1'b0);
        @(posedge clk); #1; resp_b = 1'b0; rdata = 32'd0;
        @(negedge clk);
        chk("to_stray_no_wb", wb_valid_b, 1'b0);
        chk("to_stray_state", {rd_b, st_b}, {1'b0, LSU_IDLE});
        chk("a_still_busy", {rd_a, st_a}, {1'b1, LSU_BUSY});

        // Asynchronous reset in the middle of a BUSY cycle.
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("async_rst_req", rd_a, 1'b0);
        chk("async_rst_stall", stall_a, 1'b0);
        chk("async_rst_state", st_a, LSU_IDLE);
        chk("async_rst_addr_be", {addr_a, be_a}, 36'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        resp_a = 1'b1; resp_b = 1'b1; rdata = 32'h0BAD_0BAD;
        @(negedge clk); chk("post_rst_resp_stall", stall_a, 1'b0);
        @(posedge clk); #1; resp_a = 1'b0; resp_b = 1'b0; rdata = 32'd0;
        @(negedge clk);
        chk("post_rst_no_wb", wb_valid_a, 1'b0);
        chk("post_rst_state", {rd_a, st_a}, {1'b0, LSU_IDLE});
        @(posedge clk); #1;

        // Final report
        chk("req_queue_empty", exp_req_q.size(), 0);
        chk("wb_queue_empty", exp_wb_q.size(), 0);
        chk("trap_all_seen", exp_trap_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
